// File: rtl/down_timer.sv
// ---------------------------------------------------------------------------
// down_timer
//
// Loadable down-counter with a registered terminal-count pulse. Used as a
// programmable delay (one-shot) or period generator (auto-reload).
//
// Ports
//   clk          in   rising-edge clock for all state
//   clear        in   asynchronous active-high reset
//   load         in   capture load_val into the reload register and the count
//   load_val     in   reload value, WIDTH bits
//   start        in   begin counting, or resume after stop
//   stop         in   halt counting, holding q
//   auto_reload  in   1 = periodic, 0 = one-shot (sampled every cycle)
//   q            out  current count
//   tc           out  one-cycle pulse in the cycle q reaches 0 by counting
//   busy         out  high while counting
//
// Per-cycle priority is load > stop > start > count. All outputs are
// registered, so nothing here is combinationally dependent on an input.
// ---------------------------------------------------------------------------
module down_timer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             start,
   input  logic             stop,
   input  logic             auto_reload,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_reload;
   logic [WIDTH-1:0] r_q;
   logic             r_tc;
   logic             r_busy;

   // NOTE: every register, including the reload value, is cleared by the
   // asynchronous reset so a start straight after clear sees R==0 and is
   // ignored rather than reloading from an unknown value.
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         r_state  <= IDLE;
         r_reload <= '0;
         r_q      <= '0;
         r_tc     <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout; tc defaults low so it
         // can only ever be a single-cycle pulse.
         r_tc <= 1'b0;

         if (load) begin
            // Load aborts any run in progress.
            r_reload <= load_val;
            r_q      <= load_val;
            r_state  <= IDLE;
            r_busy   <= 1'b0;
         end else if (stop && r_state == RUN) begin
            // Freeze the count; a later start resumes from here.
            r_state <= IDLE;
            r_busy  <= 1'b0;
         end else if (!stop) begin
            // stop outranks start, so a stop in IDLE/DONE also masks start.
            unique case (r_state)
               IDLE: begin
                  if (start) begin
                     if (r_q != '0) begin
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                     end else if (r_reload != '0) begin
                        r_q     <= r_reload;
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                     end
                  end
               end

               DONE: begin
                  if (start && r_reload != '0) begin
                     r_q     <= r_reload;
                     r_state <= RUN;
                     r_busy  <= 1'b1;
                  end
               end

               RUN: begin
                  if (r_q > WIDTH'(1)) begin
                     r_q <= r_q - WIDTH'(1);
                  end else if (r_q == WIDTH'(1)) begin
                     r_q  <= '0;
                     r_tc <= 1'b1;
                  end else if (auto_reload) begin
                     // q==0 is the cycle after tc: reload instead of wrapping.
                     r_q <= r_reload;
                  end else begin
                     r_state <= DONE;
                     r_busy  <= 1'b0;
                  end
               end

               default: begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign q    = r_q;
   assign tc   = r_tc;
   assign busy = r_busy;

endmodule

// File: tb/tb_down_timer.sv
// ---------------------------------------------------------------------------
// tb_down_timer
//
// Directed bench for down_timer (WIDTH=4). Inputs change 1 time unit after a
// rising edge; outputs are checked at that same point, i.e. away from the edge.
// ---------------------------------------------------------------------------
module tb_down_timer;

   localparam int WIDTH = 4;

   logic             clk;
   logic             clear;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             start;
   logic             stop;
   logic             auto_reload;
   logic [WIDTH-1:0] q;
   logic             tc;
   logic             busy;

   int n_vectors;
   int n_miscompares;

   down_timer #(.WIDTH(WIDTH)) dut (
      .clk         (clk),
      .clear       (clear),
      .load        (load),
      .load_val    (load_val),
      .start       (start),
      .stop        (stop),
      .auto_reload (auto_reload),
      .q           (q),
      .tc          (tc),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vectors++;
      if (got !== exp) begin
         n_miscompares++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Advance one clock edge, then settle 1 unit past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input int exp_q, input int exp_tc, input int exp_busy);
      check({tag, ".q"},    32'(q),    32'(exp_q));
      check({tag, ".tc"},   32'(tc),   32'(exp_tc));
      check({tag, ".busy"}, 32'(busy), 32'(exp_busy));
   endtask

   task automatic idle_inputs();
      load  = 1'b0;
      start = 1'b0;
      stop  = 1'b0;
   endtask

   task automatic do_load(input int v);
      load     = 1'b1;
      load_val = WIDTH'(v);
      step();
      load     = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // Expected q after each edge in auto-reload mode with R=2, following start.
   int auto_seq [6] = '{1, 0, 2, 1, 0, 2};

   initial begin
      n_vectors     = 0;
      n_miscompares = 0;
      clear         = 1'b1;
      load_val      = '0;
      auto_reload   = 1'b0;
      idle_inputs();

      // Reset state while clear is held.
      step();
      check_out("reset", 0, 0, 0);
      clear = 1'b0;

      // R==0 after reset: start is ignored.
      do_start();
      check_out("start_r0_after_reset", 0, 0, 0);

      // One-shot from 3.
      do_load(3);
      check_out("os_load", 3, 0, 0);
      do_start();
      check_out("os_start", 3, 0, 1);
      step(); check_out("os_q2", 2, 0, 1);
      step(); check_out("os_q1", 1, 0, 1);
      step(); check_out("os_tc", 0, 1, 1);
      step(); check_out("os_done", 0, 0, 0);
      for (int i = 0; i < 10; i++) begin
         step();
         check_out("os_hold", 0, 0, 0);
      end

      // Restart from DONE reloads R.
      do_start();
      check_out("done_restart", 3, 0, 1);

      // Auto-reload with R=2: q 2,1,0,2,1,0,2 and tc whenever q hits 0.
      auto_reload = 1'b1;
      do_load(2);
      check_out("ar_load", 2, 0, 0);
      do_start();
      check_out("ar_start", 2, 0, 1);
      for (int i = 0; i < 6; i++) begin
         step();
         check_out("ar_seq", auto_seq[i], (auto_seq[i] == 0) ? 1 : 0, 1);
      end
      auto_reload = 1'b0;

      // Stop at q=6, hold, then resume to tc.
      do_load(9);
      do_start();
      check_out("sr_start", 9, 0, 1);
      step(); step(); step();
      check_out("sr_q6", 6, 0, 1);
      stop = 1'b1;
      step();
      stop = 1'b0;
      check_out("sr_stopped", 6, 0, 0);
      step();
      check_out("sr_hold", 6, 0, 0);
      do_start();
      check_out("sr_resume", 6, 0, 1);
      for (int v = 5; v >= 1; v--) begin
         step();
         check_out("sr_count", v, 0, 1);
      end
      step(); check_out("sr_tc", 0, 1, 1);
      step(); check_out("sr_done", 0, 0, 0);

      // load beats stop and start during RUN.
      do_load(7);
      do_start();
      step();
      check_out("pri_run", 6, 0, 1);
      load     = 1'b1;
      load_val = WIDTH'(4);
      stop     = 1'b1;
      start    = 1'b1;
      step();
      idle_inputs();
      check_out("pri_load", 4, 0, 0);
      step();
      check_out("pri_idle", 4, 0, 0);

      // start with R=0 and q=0 is ignored.
      do_load(0);
      do_start();
      check_out("r0_start", 0, 0, 0);
      step();
      check_out("r0_idle", 0, 0, 0);

      // Max value: 15 decrement cycles to tc, no wrap afterwards.
      do_load(15);
      do_start();
      check_out("max_start", 15, 0, 1);
      for (int i = 1; i <= 14; i++) begin
         step();
         check_out("max_count", 15 - i, 0, 1);
      end
      step(); check_out("max_tc", 0, 1, 1);
      step(); check_out("max_done", 0, 0, 0);
      step(); check_out("max_nowrap", 0, 0, 0);

      // Asynchronous clear mid-run at q=5: outputs drop with no clock edge.
      do_load(8);
      do_start();
      step(); step(); step();
      check_out("clr_pre", 5, 0, 1);
      clear = 1'b1;
      #1;
      check_out("clr_async", 0, 0, 0);
      step();
      clear = 1'b0;
      step();
      check_out("clr_idle", 0, 0, 0);
      do_start();
      check_out("clr_r_cleared", 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
      $finish;
   end

endmodule

// File: doc/down_timer.md
# down_timer

Synchronous loadable down-counter with a terminal-count pulse. It complements the ripple up-counter: where that block counts up from `clear`, this one counts down from a programmed value. It is used as a programmable delay or period generator.

The block supports one-shot and auto-reload modes, and start/stop control. All state is in the `clk` domain, with an asynchronous active-high `clear`.

## Interface
- `WIDTH`, default 4: width of the counter and of the reload value.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `clear`  in  1  reset, asynchronous and active-high.
- `load`  in  1  capture `load_val` into the reload register R and into q.
- `load_val`  in  WIDTH  reload value.
- `start`  in  1  begin or resume counting.
- `stop`  in  1  halt counting, holding q.
- `auto_reload`  in  1  1 = periodic mode, 0 = one-shot mode; sampled each cycle.
- `q`  out  WIDTH  current count.
- `tc`  out  1  registered one-cycle pulse, high in the cycle q becomes 0 by counting.
- `busy`  out  1  high while state = RUN.

## Operation
- **States:** IDLE, RUN, DONE.
- **Reset (`clear`=1, asynchronous):** q=0, R=0, state=IDLE, tc=0, busy=0. Held for as long as `clear` is high. Reset mid-run aborts immediately.
- **Priority per cycle:** `load` > `stop` > `start` > count.
- **`load` (any state):** R<=load_val, q<=load_val, state<=IDLE, tc<=0. A run in progress is aborted.
- **`stop` in RUN:** state<=IDLE, q held, no tc. In IDLE or DONE, `stop` has no effect.
- **`start` in IDLE:**
  - q!=0: state<=RUN, q unchanged.
  - q==0 and R!=0: q<=R, state<=RUN.
  - q==0 and R==0: ignored.
- **`start` in DONE:**
  - R!=0: q<=R, state<=RUN.
  - R==0: ignored.
- **`start` while already in RUN:** no effect.
- **RUN, q>1:** q<=q-1.
- **RUN, q==1:** q<=0, tc<=1 for exactly one cycle.
- **RUN, q==0 (cycle after tc):**
  - auto_reload=1: q<=R, stay in RUN.
  - auto_reload=0: state<=DONE, q stays 0.
- **Width rules:** arithmetic is modulo 2^WIDTH. The down-count never wraps below 0, because q==0 is handled explicitly. R = 2^WIDTH-1 is legal.
- **Outputs:** tc is 0 in every cycle not listed above. busy = (state==RUN), registered.

## Timing
- `start` sampled at edge n: busy=1 after edge n. The first decrement is at edge n+1.
- One-shot from q=V (V>=1):
  - tc high after edge n+V, i.e. V cycles after start.
  - busy falls after edge n+V+1.
- Auto-reload period: R+1 cycles per tc pulse. The sequence is R, R-1, …, 1, 0, R, …
- `load` takes effect at the next edge: q=load_val and busy=0 after that edge.
- `stop` takes effect at the next edge: q frozen at the value present after that edge. A later `start` resumes from that value.
- Outputs are not combinationally dependent on inputs.
- `clear` assertion forces outputs to their reset values without waiting for a clock edge. Deassertion is synchronous to the design: the first active edge after `clear` falls is a normal cycle.

## Test plan
- **Reset:** assert `clear` mid-run with q=5, WIDTH=4 -> q=0, tc=0, busy=0 immediately (no clock edge). After release, the state is IDLE.
- **One-shot:** load 3, start, auto_reload=0 -> busy=1; q goes 3,2,1,0; tc=1 only in the q=0 cycle; then DONE with busy=0 and q held at 0 for 10 further cycles.
- **Auto-reload:** load 2, start, auto_reload=1 -> q sequence 2,1,0,2,1,0,2; tc pulses every 3 cycles; busy stays 1.
- **Stop and resume:** load 9, start, stop when q=6 -> q holds 6 and busy=0. Start again -> q goes 5,4,…; tc is seen when q reaches 0.
- **Priority and boundary:**
  - `load`=1 with load_val=4 together with `stop` and `start` during RUN -> q=4, state IDLE, no tc.
  - `start` with R=0 and q=0 -> ignored, busy stays 0.
  - load 15 (max), start, auto_reload=0 -> exactly 15 decrement cycles before tc, no wrap.
